// File: rtl/prog_sequence_detector_pkg.sv
// Shared types and width helpers for the programmable sequence detector.
package prog_seqdet_pkg;

  // Two-state serialiser: waiting for a word, or shifting one out
  typedef enum logic {
    S_IDLE,
    S_SHIFT
  } ser_state_t;

  // Width of a counter that must hold 0..max_len inclusive
  function automatic int fill_w(input int max_len);
    return $clog2(max_len + 1);
  endfunction

  // Width of a down-counter that indexes the bits of one data word
  function automatic int cnt_bits(input int data_w);
    return $clog2(data_w);
  endfunction

endpackage

// File: rtl/prog_sequence_detector_par2ser.sv
// Handshake serialiser: takes DATA_W-bit words over valid/ready and emits
// them MSB-first, one bit per cycle, with no bubble between back-to-back words.
module par2ser_hs
  import prog_seqdet_pkg::*;
#(
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] data_parallel,
  input  logic              data_valid,
  output logic              data_ready,
  output logic              ser_bit,
  output logic              ser_valid
);

  localparam int BW = cnt_bits(DATA_W);
  localparam logic [BW-1:0] LAST_IDX = BW'(DATA_W - 1);

  ser_state_t        state;
  logic [DATA_W-1:0] shreg;
  logic [BW-1:0]     bit_cnt;
  logic              accept;

  assign accept  = data_valid && data_ready;
  assign ser_bit = shreg[DATA_W-1];

  // Serialiser FSM; data_ready and ser_valid are registered alongside the state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      data_ready <= 1'b1;
      ser_valid  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            shreg      <= data_parallel;
            bit_cnt    <= LAST_IDX;
            data_ready <= 1'b0;
            ser_valid  <= 1'b1;
            state      <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (bit_cnt == '0) begin
            if (accept) begin
              shreg      <= data_parallel;
              bit_cnt    <= LAST_IDX;
              data_ready <= 1'b0;
              ser_valid  <= 1'b1;
            end else begin
              shreg      <= '0;
              data_ready <= 1'b1;
              ser_valid  <= 1'b0;
              state      <= S_IDLE;
            end
          end else begin
            shreg      <= {shreg[DATA_W-2:0], 1'b0};
            bit_cnt    <= bit_cnt - BW'(1);
            data_ready <= (bit_cnt == BW'(1));
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/prog_sequence_detector.sv
// Programmable sequence detector: serialises incoming words and matches the
// bit stream against a run-time pattern, giving Mealy/Moore hits and a
// saturating hit counter.
module prog_sequence_detector
  import prog_seqdet_pkg::*;
#(
  parameter int DATA_W  = 4,
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 16
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [DATA_W-1:0]           data_parallel,
  input  logic                        data_valid,
  output logic                        data_ready,
  input  logic [MAX_LEN-1:0]          pattern,
  input  logic [fill_w(MAX_LEN)-1:0]  pat_len,
  input  logic                        overlap_en,
  input  logic                        clear,
  output logic                        ser_bit,
  output logic                        ser_valid,
  output logic                        mealy_detected,
  output logic                        moore_detected,
  output logic [CNT_W-1:0]            match_count
);

  localparam int FW = fill_w(MAX_LEN);
  localparam logic [FW-1:0] FILL_MAX = FW'(MAX_LEN);
  localparam logic [FW:0]   FILL_ONE = (FW + 1)'(1);

  // The oldest history bit is never compared, so only MAX_LEN-1 bits are kept
  logic [MAX_LEN-2:0] hist;
  logic [FW-1:0]      fill;
  logic [FW:0]        fill_plus1;
  logic [MAX_LEN-1:0] cand;
  logic [MAX_LEN-1:0] len_mask;
  logic               len_ok;
  logic               fill_ok;
  logic               hit;

  par2ser_hs #(
    .DATA_W(DATA_W)
  ) u_ser (
    .clk          (clk),
    .reset_n      (reset_n),
    .data_parallel(data_parallel),
    .data_valid   (data_valid),
    .data_ready   (data_ready),
    .ser_bit      (ser_bit),
    .ser_valid    (ser_valid)
  );

  // Match the newest pat_len bits (history plus current bit) against the pattern
  always_comb begin
    cand       = {hist, ser_bit};
    len_ok     = (pat_len != '0) && (int'(pat_len) <= MAX_LEN);
    fill_plus1 = {1'b0, fill} + FILL_ONE;
    fill_ok    = (fill_plus1 >= {1'b0, pat_len});
    len_mask   = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      len_mask[i] = (i < int'(pat_len));
    end
    hit = ser_valid && len_ok && fill_ok && (((cand ^ pattern) & len_mask) == '0);
  end

  assign mealy_detected = hit;

  // Shift history on each valid bit; non-overlap mode restarts the fill after a hit
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hist <= '0;
      fill <= '0;
    end else if (clear) begin
      hist <= '0;
      fill <= '0;
    end else if (ser_valid) begin
      hist <= cand[MAX_LEN-2:0];
      if (hit && !overlap_en) begin
        fill <= '0;
      end else if (fill != FILL_MAX) begin
        fill <= fill + FW'(1);
      end
    end
  end

  // Registered Moore pulse and saturating hit counter; clear wins over a hit
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      moore_detected <= 1'b0;
      match_count    <= '0;
    end else if (clear) begin
      moore_detected <= 1'b0;
      match_count    <= '0;
    end else begin
      moore_detected <= hit;
      if (hit && (match_count != '1)) begin
        match_count <= match_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_prog_sequence_detector.sv
// Self-checking bench for prog_sequence_detector: a word source, an expected
// bit scoreboard and a small spec-level model of the detector.
module tb_prog_sequence_detector;
  import prog_seqdet_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  data_parallel;
  logic        data_valid;
  logic        data_ready;
  logic [7:0]  pattern;
  logic [3:0]  pat_len;
  logic        overlap_en;
  logic        clear;
  logic        ser_bit;
  logic        ser_valid;
  logic        mealy_detected;
  logic        moore_detected;
  logic [15:0] match_count;
  logic        data_ready_sat;
  logic        ser_bit_sat;
  logic        ser_valid_sat;
  logic        mealy_sat;
  logic        moore_sat;
  logic [1:0]  match_count_sat;

  int checks = 0;
  int errors = 0;

  logic [3:0] src_q[$];
  bit         exp_bits[$];
  int         hit_log[$];
  int         moore_log[$];
  int         bit_no;
  int         run_len;
  int         max_run;
  int         rdy_during;
  logic       obs_mealy;

  logic [7:0] m_hist;
  int         m_fill;
  int         m_count;
  int         m_count_sat;
  bit         m_moore;

  // Free-running clock
  always #5 clk = ~clk;

  prog_sequence_detector #(.DATA_W(4), .MAX_LEN(8), .CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .data_parallel(data_parallel),
    .data_valid(data_valid), .data_ready(data_ready), .pattern(pattern),
    .pat_len(pat_len), .overlap_en(overlap_en), .clear(clear),
    .ser_bit(ser_bit), .ser_valid(ser_valid), .mealy_detected(mealy_detected),
    .moore_detected(moore_detected), .match_count(match_count)
  );

  prog_sequence_detector #(.DATA_W(4), .MAX_LEN(8), .CNT_W(2)) dut_sat (
    .clk(clk), .reset_n(reset_n), .data_parallel(data_parallel),
    .data_valid(data_valid), .data_ready(data_ready_sat), .pattern(pattern),
    .pat_len(pat_len), .overlap_en(overlap_en), .clear(clear),
    .ser_bit(ser_bit_sat), .ser_valid(ser_valid_sat), .mealy_detected(mealy_sat),
    .moore_detected(moore_sat), .match_count(match_count_sat)
  );

  // Hard stop in case something hangs outside the bounded loops
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: observed timeout required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int qAt(input int q[$], input int idx);
    return (idx < q.size()) ? q[idx] : -1;
  endfunction

  task automatic drive();
    data_valid    = (src_q.size() != 0);
    data_parallel = (src_q.size() != 0) ? src_q[0] : 4'h0;
  endtask

  task automatic applyStimulus(input logic [3:0] w);
    src_q.push_back(w);
    drive();
  endtask

  task automatic resetModel();
    m_hist = '0; m_fill = 0; m_count = 0; m_count_sat = 0; m_moore = 0;
  endtask

  // One clock: sample and score at negedge, then handshake, then redrive after posedge
  task automatic cycle();
    bit         exp_bit;
    bit         hit;
    bit         popped;
    logic [7:0] cand;
    logic [7:0] mask;
    logic [3:0] w;
    @(negedge clk);
    checkOutput("moore", 32'(moore_detected), 32'(m_moore));
    checkOutput("count", 32'(match_count), 32'(m_count));
    checkOutput("count_sat", 32'(match_count_sat), 32'(m_count_sat));
    hit = 0; popped = 0; cand = '0;
    if (ser_valid) begin
      if (exp_bits.size() == 0) begin
        checkOutput("spurious_bit", 32'(ser_valid), 32'(0));
      end else begin
        exp_bit = exp_bits.pop_front();
        popped  = 1;
        bit_no++;
        checkOutput("ser_bit", 32'(ser_bit), 32'(exp_bit));
        cand = {m_hist[6:0], exp_bit};
        mask = '0;
        for (int i = 0; i < 8; i++) mask[i] = (i < int'(pat_len));
        hit = (int'(pat_len) >= 1) && (int'(pat_len) <= 8) &&
              (m_fill + 1 >= int'(pat_len)) && (((cand ^ pattern) & mask) == 8'h00);
        if (mealy_detected) hit_log.push_back(bit_no);
      end
    end
    if (moore_detected) moore_log.push_back(bit_no);
    obs_mealy = mealy_detected;
    checkOutput("mealy", 32'(mealy_detected), 32'(hit));
    if (clear) begin
      resetModel();
    end else begin
      m_moore = hit;
      if (popped) begin
        m_hist = cand;
        m_fill = (hit && !overlap_en) ? 0 : ((m_fill < 8) ? m_fill + 1 : 8);
      end
      if (hit) begin
        if (m_count < 65535) m_count++;
        if (m_count_sat < 3) m_count_sat++;
      end
    end
    if (ser_valid) begin
      run_len++;
      if (data_ready) rdy_during++;
    end else begin
      run_len = 0;
    end
    if (run_len > max_run) max_run = run_len;
    if (data_valid && data_ready && src_q.size() != 0) begin
      w = src_q.pop_front();
      for (int i = 3; i >= 0; i--) exp_bits.push_back(w[i]);
    end
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic waitIdle();
    int n = 0;
    do begin
      cycle();
      n++;
    end while ((src_q.size() != 0 || exp_bits.size() != 0 || ser_valid) && n < 400);
    checkOutput("drain", 32'(exp_bits.size() + src_q.size()), 32'(0));
  endtask

  task automatic doClear();
    clear = 1'b1;
    cycle();
    clear = 1'b0;
  endtask

  task automatic newTest();
    bit_no = 0;
    hit_log.delete();
    moore_log.delete();
  endtask

  // Directed test sequence
  initial begin
    int         n;
    int         ones;
    logic [3:0] w;
    reset_n = 1'b0; data_parallel = '0; data_valid = 0; pattern = '0;
    pat_len = '0; overlap_en = 1'b1; clear = 1'b0;
    resetModel();
    run_len = 0; max_run = 0; rdy_during = 0; bit_no = 0; obs_mealy = 0;
    #12;
    checkOutput("rst_ready", 32'(data_ready), 32'(1));
    checkOutput("rst_valid", 32'(ser_valid), 32'(0));
    checkOutput("rst_bit", 32'(ser_bit), 32'(0));
    checkOutput("rst_count", 32'(match_count), 32'(0));
    reset_n = 1'b1;

    $display("[TB] overlap mode");
    doClear();
    pattern = 8'h0B; pat_len = 4'd4; overlap_en = 1'b1;
    newTest();
    applyStimulus(4'b1011);
    applyStimulus(4'b0110);
    waitIdle();
    checkOutput("ov_nhits", 32'(hit_log.size()), 32'(2));
    checkOutput("ov_hit0", 32'(qAt(hit_log, 0)), 32'(4));
    checkOutput("ov_hit1", 32'(qAt(hit_log, 1)), 32'(7));
    checkOutput("ov_nmoore", 32'(moore_log.size()), 32'(2));
    checkOutput("ov_moore0", 32'(qAt(moore_log, 0)), 32'(5));
    checkOutput("ov_moore1", 32'(qAt(moore_log, 1)), 32'(8));
    checkOutput("ov_count", 32'(match_count), 32'(2));

    $display("[TB] non-overlap mode");
    doClear();
    overlap_en = 1'b0;
    newTest();
    applyStimulus(4'b1011);
    applyStimulus(4'b0110);
    waitIdle();
    checkOutput("nov_nhits", 32'(hit_log.size()), 32'(1));
    checkOutput("nov_hit0", 32'(qAt(hit_log, 0)), 32'(4));
    checkOutput("nov_moore0", 32'(qAt(moore_log, 0)), 32'(5));
    checkOutput("nov_count", 32'(match_count), 32'(1));

    $display("[TB] streaming and stall");
    doClear();
    overlap_en = 1'b1;
    newTest();
    run_len = 0; max_run = 0; rdy_during = 0;
    applyStimulus(4'b1100);
    applyStimulus(4'b1011);
    applyStimulus(4'b0011);
    waitIdle();
    checkOutput("stream_run", 32'(max_run), 32'(12));
    checkOutput("stream_ready", 32'(rdy_during), 32'(3));
    applyStimulus(4'b1001);
    waitIdle();
    for (int i = 0; i < 2; i++) begin
      cycle();
      checkOutput("stall_ready", 32'(data_ready), 32'(1));
      checkOutput("stall_valid", 32'(ser_valid), 32'(0));
      checkOutput("stall_fsm", 32'(dut.u_ser.state), 32'(S_IDLE));
    end
    applyStimulus(4'b0111);
    waitIdle();
    checkOutput("stream_bits", 32'(bit_no), 32'(20));

    $display("[TB] saturation and clear");
    doClear();
    pattern = 8'h01; pat_len = 4'd1; overlap_en = 1'b1;
    newTest();
    applyStimulus(4'b1111);
    applyStimulus(4'b1000);
    waitIdle();
    checkOutput("sat_main", 32'(match_count), 32'(5));
    checkOutput("sat_count", 32'(match_count_sat), 32'(3));
    newTest();
    applyStimulus(4'b1100);
    n = 0;
    while (bit_no < 1 && n < 20) begin
      cycle();
      n++;
    end
    checkOutput("clr_reach", 32'(bit_no), 32'(1));
    clear = 1'b1;
    cycle();
    clear = 1'b0;
    checkOutput("clr_mealy", 32'(obs_mealy), 32'(1));
    checkOutput("clr_count", 32'(match_count), 32'(0));
    checkOutput("clr_count_sat", 32'(match_count_sat), 32'(0));
    checkOutput("clr_moore", 32'(moore_detected), 32'(0));
    waitIdle();

    $display("[TB] disabled lengths");
    for (int k = 0; k < 2; k++) begin
      doClear();
      pattern = 8'hA5;
      pat_len = (k == 0) ? 4'd0 : 4'd9;
      newTest();
      for (int i = 0; i < 16; i++) applyStimulus(4'($urandom_range(15, 0)));
      waitIdle();
      checkOutput("dis_hits", 32'(hit_log.size()), 32'(0));
      checkOutput("dis_count", 32'(match_count), 32'(0));
    end
    doClear();
    pattern = 8'h01; pat_len = 4'd1;
    newTest();
    ones = 0;
    for (int i = 0; i < 16; i++) begin
      w = 4'($urandom_range(15, 0));
      ones += $countones(w);
      applyStimulus(w);
    end
    waitIdle();
    checkOutput("len1_count", 32'(match_count), 32'(ones));

    $display("[TB] async reset mid-word");
    applyStimulus(4'b1010);
    cycle();
    cycle();
    cycle();
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("arst_ready", 32'(data_ready), 32'(1));
    checkOutput("arst_valid", 32'(ser_valid), 32'(0));
    checkOutput("arst_mealy", 32'(mealy_detected), 32'(0));
    checkOutput("arst_moore", 32'(moore_detected), 32'(0));
    checkOutput("arst_count", 32'(match_count), 32'(0));
    src_q.delete();
    exp_bits.delete();
    resetModel();
    drive();
    cycle();
    cycle();
    reset_n = 1'b1;
    newTest();
    applyStimulus(4'b0101);
    waitIdle();
    checkOutput("post_rst_bits", 32'(bit_no), 32'(4));
    checkOutput("post_rst_count", 32'(match_count), 32'(2));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
